// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - op codes, segment patterns and next-state function for shift_reg_n
package shift_pkg;

    // Widest register the next-state function handles; callers pass the real width.
    localparam int MAXW = 64;

    localparam logic [2:0] OP_CLR  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_LSR  = 3'd2;
    localparam logic [2:0] OP_LSL  = 3'd3;
    localparam logic [2:0] OP_ASR  = 3'd4;
    localparam logic [2:0] OP_LFSR = 3'd5;
    localparam logic [2:0] OP_ROR  = 3'd6;
    localparam logic [2:0] OP_ROL  = 3'd7;

    // Active-low segment patterns, bit order gfedcba.
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // Next register value for one advance; operands are zero-extended to MAXW
    // and the result is masked back to the live width.
    function automatic logic [MAXW-1:0] next_q(
        input logic [2:0]      op,
        input logic [MAXW-1:0] q,
        input logic [MAXW-1:0] data_in,
        input int              amt,
        input logic            sin,
        input int              width,
        input logic [MAXW-1:0] taps
    );
        logic [MAXW-1:0] mask;
        logic [MAXW-1:0] fill_hi;
        logic [MAXW-1:0] fill_lo;
        logic [MAXW-1:0] r;
        logic            msb;
        logic            fb;
        mask    = (width >= MAXW) ? '1 : ((MAXW'(1) << width) - MAXW'(1));
        fill_hi = mask & ~(mask >> amt);
        fill_lo = (MAXW'(1) << amt) - MAXW'(1);
        msb     = |(q & (MAXW'(1) << (width - 1)));
        // Zero-escape term lets the all-zero state join the maximal cycle.
        fb      = (^(q & taps)) ^ ((q >> 1) == '0);
        case (op)
            OP_CLR:  r = '0;
            OP_LOAD: r = data_in;
            OP_LSR:  r = (q >> amt) | (sin ? fill_hi : '0);
            OP_LSL:  r = (q << amt) | (sin ? fill_lo : '0);
            OP_ASR:  r = (q >> amt) | (msb ? fill_hi : '0);
            OP_LFSR: r = (q >> 1) | (MAXW'(fb) << (width - 1));
            OP_ROR:  r = (q >> amt) | (q << (width - amt));
            default: r = (q << amt) | (q >> (width - amt));
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low 7-segment decoder
module hex_to_seg7
    import shift_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Fixed lookup of all sixteen hex glyphs.
    always_comb begin
        seg = SEG_0;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/shift_reg_n.sv
// rtl/shift_reg_n.sv - universal shift register with LFSR step, prescaled auto-run and hex display
module shift_reg_n
    import shift_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 16'h002D,
    parameter int               DIV       = 50_000_000,
    localparam int              AW        = $clog2(WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [2:0]               op,
    input  logic [AW-1:0]            amt,
    input  logic                     sin,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     step,
    input  logic                     run,
    output logic [WIDTH-1:0]         q,
    output logic [7*(WIDTH/4)-1:0]   seg
);

    localparam int            NDIG = WIDTH / 4;
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0]      cnt;
    logic               tick;
    logic               step_d;
    logic               step_rise;
    logic               advance;
    logic [WIDTH-1:0]   q_next;
    logic [7*NDIG-1:0]  seg_next;

    assign tick      = (cnt == LAST);
    assign step_rise = step & ~step_d;
    // A step edge and a tick in the same cycle merge into a single advance.
    assign advance   = en & (step_rise | (run & tick));
    assign q_next    = WIDTH'(next_q(op, MAXW'(q), MAXW'(data_in), int'(amt), sin,
                                     WIDTH, MAXW'(LFSR_TAPS)));

    // Prescaler: counts only while enabled and running, wraps on tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || !run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Step history tracks the input every cycle so en never masks an edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_d <= 1'b0;
        end else begin
            step_d <= step;
        end
    end

    // Register value: cleared while disabled, updated only on an advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (!en) begin
            q <= '0;
        end else if (advance) begin
            q <= q_next;
        end
    end

    for (genvar k = 0; k < NDIG; k++) begin : g_dig
        hex_to_seg7 u_dec (
            .hex (q[4*k +: 4]),
            .seg (seg_next[7*k +: 7])
        );
    end

    // Display register, one clock behind q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= {NDIG{SEG_0}};
        end else begin
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_shift_reg_n.sv
// tb/tb_shift_reg_n.sv - self-checking bench for shift_reg_n
module tb_shift_reg_n;

    localparam logic [2:0] C_CLR  = 3'd0;
    localparam logic [2:0] C_LOAD = 3'd1;
    localparam logic [2:0] C_LSR  = 3'd2;
    localparam logic [2:0] C_LSL  = 3'd3;
    localparam logic [2:0] C_ASR  = 3'd4;
    localparam logic [2:0] C_LFSR = 3'd5;
    localparam logic [2:0] C_ROR  = 3'd6;
    localparam logic [2:0] C_ROL  = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        en_a = 1'b0;
    logic [2:0]  op_a = 3'd0;
    logic [3:0]  amt_a = 4'd0;
    logic        sin_a = 1'b0;
    logic [15:0] data_a = 16'd0;
    logic        step_a = 1'b0;
    logic        run_a = 1'b0;
    logic [15:0] q_a;
    logic [27:0] seg_a;

    logic        en_b = 1'b0;
    logic [2:0]  op_b = 3'd0;
    logic [2:0]  amt_b = 3'd0;
    logic        sin_b = 1'b0;
    logic [7:0]  data_b = 8'd0;
    logic        step_b = 1'b0;
    logic        run_b = 1'b0;
    logic [7:0]  q_b;
    logic [13:0] seg_b;

    int n_err = 0;
    int n_checks = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    shift_reg_n #(.WIDTH(16), .LFSR_TAPS(16'h002D), .DIV(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .op(op_a), .amt(amt_a), .sin(sin_a),
        .data_in(data_a), .step(step_a), .run(run_a), .q(q_a), .seg(seg_a)
    );

    shift_reg_n #(.WIDTH(8), .LFSR_TAPS(8'h1D), .DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .op(op_b), .amt(amt_b), .sin(sin_b),
        .data_in(data_b), .step(step_b), .run(run_b), .q(q_b), .seg(seg_b)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] exp_seg16(input logic [15:0] v);
        logic [27:0] r;
        for (int k = 0; k < 4; k++) r[7*k +: 7] = seg_tab[(v >> (4*k)) & 16'hF];
        return r;
    endfunction

    function automatic longint unsigned p2(input int n);
        longint unsigned r = 1;
        for (int i = 0; i < n; i++) r = r * 2;
        return r;
    endfunction

    // Arithmetic reference: shifts as multiply/divide by powers of two.
    function automatic longint unsigned model(input int o, input longint unsigned qv,
                                              input longint unsigned d, input int a,
                                              input int s, input int w,
                                              input longint unsigned taps);
        longint unsigned m = p2(w);
        int ones = 0;
        int fb;
        case (o)
            0: return 0;
            1: return d % m;
            2: return qv / p2(a) + (s != 0 ? m - p2(w - a) : 0);
            3: return (qv * p2(a)) % m + (s != 0 ? p2(a) - 1 : 0);
            4: return qv / p2(a) + (qv >= m / 2 ? m - p2(w - a) : 0);
            5: begin
                for (int i = 0; i < w; i++)
                    if (((qv / p2(i)) % 2 == 1) && ((taps / p2(i)) % 2 == 1)) ones++;
                fb = (ones % 2) ^ (qv < 2 ? 1 : 0);
                return qv / 2 + longint'(fb) * (m / 2);
            end
            6: return qv / p2(a) + (qv % p2(a)) * p2(w - a);
            default: return (qv * p2(a)) % m + qv / p2(w - a);
        endcase
    endfunction

    task automatic apply_a(input logic [2:0] o, input logic [3:0] a, input logic s,
                           input logic [15:0] d);
        @(negedge clk);
        op_a = o; amt_a = a; sin_a = s; data_a = d; step_a = 1'b1;
        @(negedge clk);
        step_a = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [3:0]  amt;
        logic        sin;
        logic [15:0] data;
        logic [15:0] pre;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];
    longint unsigned mq;
    logic [7:0] lfsr_seen [256];
    int distinct;
    int first_zero;

    initial begin
        vecs.push_back('{"lsr4_s1",  C_LSR,  4'd4,  1'b1, 16'h0, 16'h8001, 16'hF800});
        vecs.push_back('{"lsl3_s0",  C_LSL,  4'd3,  1'b0, 16'h0, 16'h8001, 16'h0008});
        vecs.push_back('{"asr4",     C_ASR,  4'd4,  1'b0, 16'h0, 16'h8001, 16'hF800});
        vecs.push_back('{"ror1",     C_ROR,  4'd1,  1'b0, 16'h0, 16'h8001, 16'hC000});
        vecs.push_back('{"rol15",    C_ROL,  4'd15, 1'b0, 16'h0, 16'h8001, 16'hC000});
        vecs.push_back('{"lsr0",     C_LSR,  4'd0,  1'b1, 16'h0, 16'h8001, 16'h8001});
        vecs.push_back('{"rol0",     C_ROL,  4'd0,  1'b0, 16'h0, 16'h8001, 16'h8001});
        vecs.push_back('{"asr0",     C_ASR,  4'd0,  1'b0, 16'h0, 16'h8001, 16'h8001});
        vecs.push_back('{"lsl4_s1",  C_LSL,  4'd4,  1'b1, 16'h0, 16'h8001, 16'h001F});
        vecs.push_back('{"asr4_pos", C_ASR,  4'd4,  1'b0, 16'h0, 16'h7001, 16'h0700});
        vecs.push_back('{"clr",      C_CLR,  4'd3,  1'b1, 16'h0, 16'h1234, 16'h0000});
        vecs.push_back('{"lfsr16",   C_LFSR, 4'd7,  1'b0, 16'h0, 16'h0001, 16'h0000});
        vecs.push_back('{"lfsr16_b", C_LFSR, 4'd0,  1'b0, 16'h0, 16'h0000, 16'h8000});

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_q", q_a, 16'h0);
        check("reset_seg", seg_a, {4{7'b1000000}});
        rst_n = 1'b1;
        en_a = 1'b1;

        // Load and display
        apply_a(C_LOAD, 4'd0, 1'b0, 16'hA5C3);
        check("load_q", q_a, 16'hA5C3);
        @(negedge clk);
        check("load_seg", seg_a, {7'b0001000, 7'b0010010, 7'b1000110, 7'b0110000});

        // Mid-clock asynchronous reset
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_q", q_a, 16'h0);
        check("async_rst_seg", seg_a, {4{7'b1000000}});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_rst", q_a, 16'h0);

        // Table vectors
        for (int i = 0; i < vecs.size(); i++) begin
            apply_a(C_LOAD, 4'd0, 1'b0, vecs[i].pre);
            apply_a(vecs[i].op, vecs[i].amt, vecs[i].sin, vecs[i].pre ^ 16'h5A5A);
            check({"vec_", vecs[i].name}, q_a, vecs[i].exp);
            @(negedge clk);
            check({"vec_seg_", vecs[i].name}, seg_a, exp_seg16(vecs[i].exp));
        end

        // Randomised operations against the arithmetic model
        mq = 0;
        apply_a(C_CLR, 4'd0, 1'b0, 16'h0);
        for (int i = 0; i < 150; i++) begin
            logic [2:0]  o;
            logic [3:0]  a;
            logic        s;
            logic [15:0] d;
            o = 3'($urandom_range(0, 7));
            a = 4'($urandom_range(0, 15));
            s = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            if (o == C_CLR && ($urandom_range(0, 3) != 0)) o = C_LOAD;
            apply_a(o, a, s, d);
            mq = model(int'(o), mq, longint'(d), int'(a), int'(s), 16, 64'h002D);
            check($sformatf("rand%0d_op%0d_amt%0d", i, o, a), q_a, mq);
            if (i % 10 == 0) begin
                @(negedge clk);
                check($sformatf("rand%0d_seg", i), seg_a, exp_seg16(16'(mq)));
            end
        end

        // Step edge coinciding with tick gives one advance
        apply_a(C_LOAD, 4'd0, 1'b0, 16'h0001);
        op_a = C_ROL; amt_a = 4'd1; run_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("run_wait%0d", i), q_a, 16'h0001);
        end
        step_a = 1'b1;
        @(negedge clk);
        check("tick_and_step", q_a, 16'h0002);
        run_a = 1'b0;
        step_a = 1'b0;
        @(negedge clk);
        step_a = 1'b1;
        repeat (10) @(negedge clk);
        check("step_held", q_a, 16'h0004);
        step_a = 1'b0;

        // Enable low clears q and prescaler, ignores step edges
        apply_a(C_LOAD, 4'd0, 1'b0, 16'h5555);
        op_a = C_LOAD; data_a = 16'h1234; run_a = 1'b1;
        repeat (2) @(negedge clk);
        check("en_pre", q_a, 16'h5555);
        en_a = 1'b0;
        @(negedge clk);
        check("en_low_clr", q_a, 16'h0);
        step_a = 1'b1;
        @(negedge clk);
        check("en_low_step", q_a, 16'h0);
        step_a = 1'b0;
        @(negedge clk);
        en_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("en_wait%0d", i), q_a, 16'h0);
        end
        @(negedge clk);
        check("en_first_tick", q_a, 16'h1234);
        run_a = 1'b0;

        // 8-bit LFSR full period with DIV=1
        check("lfsr_start", q_b, 8'h00);
        en_b = 1'b1; op_b = C_LFSR; amt_b = 3'd5; run_b = 1'b1;
        mq = 0;
        first_zero = -1;
        for (int s = 1; s <= 256; s++) begin
            @(negedge clk);
            mq = model(5, mq, 0, 0, 0, 8, 64'h1D);
            check($sformatf("lfsr_step%0d", s), q_b, mq);
            lfsr_seen[s - 1] = q_b;
            if (q_b == 8'h00 && first_zero < 0) first_zero = s;
            if (s == 1) check("lfsr_first", q_b, 8'h80);
            if (s == 2) check("lfsr_second", q_b, 8'h40);
            if (s == 3) check("lfsr_third", q_b, 8'h20);
        end
        run_b = 1'b0;
        distinct = 0;
        for (int v = 0; v < 256; v++) begin
            bit found = 1'b0;
            for (int j = 0; j < 256; j++) if (lfsr_seen[j] == 8'(v)) found = 1'b1;
            if (found) distinct++;
        end
        check("lfsr_distinct", 64'(distinct), 64'd256);
        check("lfsr_zero_at_256", 64'(first_zero), 64'd256);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
